// File: rtl/vga_pkg.sv
// Shared types and constants for the text-mode VRAM write path.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        LINE_CLR,
        FULL_CLR
    } state_t;

    localparam int unsigned COLS     = 40;
    localparam int unsigned ROWS     = 24;
    localparam logic [5:0]  CLR_CHAR = 6'd32;

    // Control characters recognised by the decoder (Apple-1 keyboard codes)
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] CR_HI  = 8'h8D;
    localparam logic [7:0] NUL    = 8'h00;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] DEL    = 8'h7F;
    localparam logic [7:0] ESC_HI = 8'h9B;

    // Result of a newline: new cursor row, new scroll base, and whether a line clear is due
    typedef struct packed {
        logic [4:0] v;
        logic [4:0] sb;
        logic       scroll;
    } nl_t;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO for TX characters; push while full is accepted only alongside a pop.
module char_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush & ~empty;
    assign dout    = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk25) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vram_write_sched.sv
// Sequences all text VRAM writes: character output, cursor/scroll tracking, line and screen clears.
module vram_write_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COLS       = vga_pkg::COLS,
    parameter int unsigned ROWS       = vga_pkg::ROWS,
    parameter logic [5:0]  CLR_CHAR   = vga_pkg::CLR_CHAR
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clr_req,
    output logic        vram_w_en,
    output logic [10:0] vram_w_addr,
    output logic [5:0]  vram_din,
    output logic [5:0]  cursor_h,
    output logic [4:0]  cursor_v,
    output logic [4:0]  scroll_base,
    output logic        busy
);

    import vga_pkg::*;

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] ROWS_W   = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'd31;

    state_t     state_q, state_d;
    logic [7:0] char_q, char_d;
    logic [5:0] h_q, h_d;
    logic [4:0] v_q, v_d;
    logic [4:0] sb_q, sb_d;
    logic [4:0] row_q, row_d;
    logic [5:0] col_q, col_d;
    logic       clr_pend_q;
    logic       enter_full;
    logic       do_nl;
    nl_t        nl;

    logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    // Advance the cursor row; hitting the row just past the visible window scrolls by one
    function automatic nl_t newline(input logic [4:0] v, input logic [4:0] sb);
        nl_t        r;
        logic [4:0] bottom;
        bottom   = sb + ROWS_W;
        r.v      = v + 5'd1;
        r.scroll = (r.v == bottom);
        r.sb     = r.scroll ? sb + 5'd1 : sb;
        return r;
    endfunction

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk25 (clk25),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (char_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A full FIFO still takes a char in the cycle it is popped; nothing is taken while flushing
    assign char_ready  = (~fifo_full | fifo_pop) & ~fifo_flush;
    assign fifo_push   = char_valid & char_ready;
    assign cursor_h    = h_q;
    assign cursor_v    = v_q;
    assign scroll_base = sb_q;
    assign busy        = (state_q != IDLE);

    // State and datapath registers
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            char_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            sb_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            h_q     <= h_d;
            v_q     <= v_d;
            sb_q    <= sb_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Sticky clear request; dropped once the full clear starts
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clr_pend_q <= 1'b0;
        end else if (enter_full) begin
            clr_pend_q <= 1'b0;
        end else if (clr_req) begin
            clr_pend_q <= 1'b1;
        end
    end

    // Next-state, cursor update and VRAM write port
    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        h_d         = h_q;
        v_d         = v_q;
        sb_d        = sb_q;
        row_d       = row_q;
        col_d       = col_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        enter_full  = 1'b0;
        do_nl       = 1'b0;
        nl          = '0;
        vram_w_en   = 1'b0;
        vram_w_addr = '0;
        vram_din    = '0;

        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = FULL_CLR;
                    enter_full = 1'b1;
                    h_d        = '0;
                    v_d        = '0;
                    sb_d       = '0;
                    row_d      = '0;
                    col_d      = '0;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    char_d   = fifo_dout;
                    state_d  = DECODE;
                end
            end

            DECODE: begin
                state_d = IDLE;
                if (char_q == CR || char_q == CR_HI) begin
                    do_nl = 1'b1;
                end else if (!(char_q == NUL || char_q == LF || char_q == DEL ||
                               char_q == ESC_HI)) begin
                    vram_w_en   = 1'b1;
                    vram_w_addr = {v_q, h_q};
                    vram_din    = {~char_q[6], char_q[4:0]};
                    h_d         = h_q + 6'd1;
                    do_nl       = (h_q == LAST_COL);
                end
                if (do_nl) begin
                    nl   = newline(v_q, sb_q);
                    h_d  = '0;
                    v_d  = nl.v;
                    sb_d = nl.sb;
                    if (nl.scroll) begin
                        state_d = LINE_CLR;
                        row_d   = nl.v;
                        col_d   = '0;
                    end
                end
            end

            LINE_CLR: begin
                vram_w_en   = 1'b1;
                vram_w_addr = {row_q, col_q};
                vram_din    = CLR_CHAR;
                col_d       = col_q + 6'd1;
                if (col_q == LAST_COL) state_d = IDLE;
            end

            FULL_CLR: begin
                // First cycle of the sweep doubles as the FIFO flush
                fifo_flush  = (row_q == '0) && (col_q == '0);
                vram_w_en   = 1'b1;
                vram_w_addr = {row_q, col_q};
                vram_din    = CLR_CHAR;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + 5'd1;
                    if (row_q == LAST_ROW) state_d = IDLE;
                end else begin
                    col_d = col_q + 6'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// Self-checking bench for vram_write_sched: directed table, corner sequences, random vs model.
module tb_vram_write_sched;

    logic        clk25, rst;
    logic        char_valid, char_ready, clr_req;
    logic [7:0]  char_data;
    logic        vram_w_en, busy;
    logic [10:0] vram_w_addr;
    logic [5:0]  vram_din, cursor_h;
    logic [4:0]  cursor_v, scroll_base;

    int vectors = 0;
    int miscompares = 0;

    // Observed and expected write streams, entries are {addr[10:0], din[5:0]}
    logic [16:0] wq[$];
    logic [16:0] eq[$];
    int mh, mv, msb;

    typedef struct {
        logic [7:0]  ch;
        bit          wr;
        logic [10:0] addr;
        logic [5:0]  din;
        int          h;
        int          v;
    } vec_t;

    vram_write_sched dut (
        .clk25       (clk25),
        .rst         (rst),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .clr_req     (clr_req),
        .vram_w_en   (vram_w_en),
        .vram_w_addr (vram_w_addr),
        .vram_din    (vram_din),
        .cursor_h    (cursor_h),
        .cursor_v    (cursor_v),
        .scroll_base (scroll_base),
        .busy        (busy)
    );

    initial begin
        clk25 = 1'b0;
        forever #20 clk25 = ~clk25;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk25) begin
        if (!rst && vram_w_en) wq.push_back({vram_w_addr, vram_din});
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    // Reference model: the screen rules in plain arithmetic
    task automatic m_newline();
        mh = 0;
        mv = (mv + 1) % 32;
        if (mv == (msb + 24) % 32) begin
            msb = (msb + 1) % 32;
            for (int c = 0; c < 40; c++) eq.push_back({5'(mv), 6'(c), 6'd32});
        end
    endtask

    task automatic m_char(input logic [7:0] c);
        if (c == 8'h0D || c == 8'h8D) begin
            m_newline();
        end else if (!(c == 8'h00 || c == 8'h0A || c == 8'h7F || c == 8'h9B)) begin
            eq.push_back({5'(mv), 6'(mh), ~c[6], c[4:0]});
            mh = mh + 1;
            if (mh == 40) m_newline();
        end
    endtask

    task automatic m_clear();
        mh = 0;
        mv = 0;
        msb = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 40; c++) eq.push_back({5'(r), 6'(c), 6'd32});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        char_data = 8'h00;
        clr_req = 1'b0;
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        rst = 1'b0;
        wq.delete();
        eq.delete();
        mh = 0;
        mv = 0;
        msb = 0;
        tick();
    endtask

    task automatic push(input logic [7:0] c);
        int n;
        n = 0;
        char_data = c;
        char_valid = 1'b1;
        while (!char_ready && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("push_timeout", 0, 1);
        tick();
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 5000) begin
            tick();
            if (!busy) quiet++;
            else quiet = 0;
            n++;
        end
        if (quiet < 4) check("idle_timeout", 0, 1);
    endtask

    task automatic compare_q(input string name);
        int n;
        bit ok;
        check({name, "_count"}, wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            ok = (wq[i] === eq[i]);
            check($sformatf("%s_write%0d", name, i), wq[i], eq[i]);
            if (!ok) break;
        end
        wq.delete();
        eq.delete();
    endtask

    initial begin
        vec_t tbl[12];
        logic [7:0] fill[5];
        bit exp_rdy[5];
        int busy_run;
        logic [7:0] c;
        int r;

        tbl[0]  = '{8'hC1, 1'b1, 11'h000, 6'h01, 1, 0};
        tbl[1]  = '{8'h9B, 1'b0, 11'h000, 6'h00, 1, 0};
        tbl[2]  = '{8'h0A, 1'b0, 11'h000, 6'h00, 1, 0};
        tbl[3]  = '{8'h7F, 1'b0, 11'h000, 6'h00, 1, 0};
        tbl[4]  = '{8'h00, 1'b0, 11'h000, 6'h00, 1, 0};
        tbl[5]  = '{8'hB0, 1'b1, 11'h001, 6'h30, 2, 0};
        tbl[6]  = '{8'hA0, 1'b1, 11'h002, 6'h20, 3, 0};
        tbl[7]  = '{8'h8D, 1'b0, 11'h000, 6'h00, 0, 1};
        tbl[8]  = '{8'hDA, 1'b1, 11'h040, 6'h1A, 1, 1};
        tbl[9]  = '{8'h0D, 1'b0, 11'h000, 6'h00, 0, 2};
        tbl[10] = '{8'h41, 1'b1, 11'h080, 6'h01, 1, 2};
        tbl[11] = '{8'h8A, 1'b1, 11'h081, 6'h2A, 2, 2};

        // Reset values
        do_reset();
        check("rst_ready", char_ready, 1);
        check("rst_w_en", vram_w_en, 0);
        check("rst_addr", vram_w_addr, 0);
        check("rst_din", vram_din, 0);
        check("rst_cursor_h", cursor_h, 0);
        check("rst_cursor_v", cursor_v, 0);
        check("rst_scroll", scroll_base, 0);
        check("rst_busy", busy, 0);

        // Latency of a single char into an empty FIFO
        char_data = 8'hC1;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        check("lat_pop_cycle_w_en", vram_w_en, 0);
        tick();
        check("lat_w_en", vram_w_en, 1);
        check("lat_addr", vram_w_addr, 11'h000);
        check("lat_din", vram_din, 6'h01);
        tick();
        check("lat_cursor_h", cursor_h, 1);
        wait_idle();

        // Directed table
        do_reset();
        foreach (tbl[i]) begin
            wq.delete();
            push(tbl[i].ch);
            wait_idle();
            check($sformatf("tbl%0d_writes", i), wq.size(), tbl[i].wr ? 1 : 0);
            if (tbl[i].wr && wq.size() > 0) begin
                check($sformatf("tbl%0d_addr", i), wq[0][16:6], tbl[i].addr);
                check($sformatf("tbl%0d_din", i), wq[0][5:0], tbl[i].din);
            end
            check($sformatf("tbl%0d_cursor_h", i), cursor_h, tbl[i].h);
            check($sformatf("tbl%0d_cursor_v", i), cursor_v, tbl[i].v);
        end

        // Line wrap after 40 printable chars
        do_reset();
        for (int i = 0; i < 40; i++) begin
            c = 8'hC1 + 8'(i % 26);
            push(c);
            m_char(c);
        end
        push(8'hC2);
        m_char(8'hC2);
        wait_idle();
        if (wq.size() > 0) check("wrap_last_write", wq[wq.size()-1], {5'd1, 6'd0, 6'h02});
        compare_q("wrap");
        check("wrap_cursor_h", cursor_h, 1);
        check("wrap_cursor_v", cursor_v, 1);

        // 24 CRs: the last one scrolls and clears row 24
        do_reset();
        for (int i = 0; i < 23; i++) begin
            push(8'h0D);
            m_char(8'h0D);
        end
        wait_idle();
        push(8'h0D);
        m_char(8'h0D);
        busy_run = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (busy) busy_run++;
            else if (busy_run > 0) break;
        end
        check("scroll_busy_cycles", busy_run, 41);
        wait_idle();
        check("scroll_base_1", scroll_base, 1);
        check("scroll_cursor_v", cursor_v, 24);
        compare_q("scroll");

        // FIFO fills while a line clear is running
        push(8'h0D);
        m_char(8'h0D);
        tick();
        tick();
        check("fill_in_line_clr", busy, 1);
        fill[0] = 8'hC3;
        fill[1] = 8'hC4;
        fill[2] = 8'hC5;
        fill[3] = 8'hC6;
        fill[4] = 8'hC7;
        exp_rdy[0] = 1'b1;
        exp_rdy[1] = 1'b1;
        exp_rdy[2] = 1'b1;
        exp_rdy[3] = 1'b1;
        exp_rdy[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            char_data = fill[k];
            char_valid = 1'b1;
            check($sformatf("fill_ready%0d", k), char_ready, exp_rdy[k]);
            tick();
        end
        char_valid = 1'b0;
        check("fill_full_ready", char_ready, 0);
        for (int k = 0; k < 4; k++) m_char(fill[k]);
        wait_idle();
        compare_q("fill");
        check("fill_cursor_h", cursor_h, 4);

        // Clear requested mid-line-clear: line completes, queued char is flushed
        push(8'h0D);
        m_char(8'h0D);
        repeat (5) tick();
        push(8'hC8);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        m_clear();
        wait_idle();
        compare_q("clr");
        check("clr_cursor_h", cursor_h, 0);
        check("clr_cursor_v", cursor_v, 0);
        check("clr_scroll", scroll_base, 0);
        check("clr_ready", char_ready, 1);
        repeat (10) tick();
        check("clr_fifo_empty_writes", wq.size(), 0);
        check("clr_fifo_empty_busy", busy, 0);

        // Reset in the middle of a full clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        check("fc_busy", busy, 1);
        #5;
        rst = 1'b1;
        #1;
        check("fc_rst_w_en", vram_w_en, 0);
        check("fc_rst_busy", busy, 0);
        check("fc_rst_ready", char_ready, 1);
        check("fc_rst_addr", vram_w_addr, 0);
        tick();
        check("fc_rst_w_en_edge", vram_w_en, 0);
        check("fc_rst_cursor_h", cursor_h, 0);
        check("fc_rst_cursor_v", cursor_v, 0);
        check("fc_rst_scroll", scroll_base, 0);

        // Random char stream against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                c = ($urandom_range(0, 1) == 1) ? 8'h8D : 8'h0D;
            end else if (r < 22) begin
                case ($urandom_range(0, 3))
                    0: c = 8'h00;
                    1: c = 8'h0A;
                    2: c = 8'h7F;
                    default: c = 8'h9B;
                endcase
            end else begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h0D || c == 8'h8D || c == 8'h00 || c == 8'h0A ||
                    c == 8'h7F || c == 8'h9B) c = 8'hC1;
            end
            repeat ($urandom_range(0, 2)) tick();
            push(c);
            m_char(c);
        end
        wait_idle();
        compare_q("rand");
        check("rand_cursor_h", cursor_h, mh);
        check("rand_cursor_v", cursor_v, mv);
        check("rand_scroll", scroll_base, msb);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
